instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the MIPS datapath. Owns the architectural PC register and issues sequential word fetches to instruction memory over a valid/ready request channel. Returned instructions are buffered in order in a small queue for the decode stage, each tagged with its PC and PC+4. A branch redirect from the PC-add stage (taken `Branch && Zero` target) flushes the queue and discards fetches still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `DEPTH`, 2, entries in the fetch queue; also the maximum number of fetches in flight. Power of two, 2..8.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch byte address; always word-aligned.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_resp_valid`  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  branch taken; load new PC.
- `redirect_target`  in  32  new PC; bits [1:0] ignored and forced to 0.
- `if_valid`  out  1  queue head valid toward decode.
- `if_ready`  in  1  decode consumes head this cycle.
- `if_instr`  out  32  instruction at queue head.
- `if_pc`  out  32  address of head instruction.
- `if_pc_plus_4`  out  32  `if_pc + 4`, mod 2^32.

## Operation
- State:
  - `pc` (next fetch address).
  - `inflight` counter, 0..DEPTH.
  - `drop` counter, 0..DEPTH: responses still to be discarded.
  - FIFO of {instr, pc}, DEPTH entries.
  - Per in-flight request, an address FIFO so each response is paired with its PC.
- Credit rule: `imem_req_valid = !rst && !redirect_valid && (inflight - drop + fifo_count) < DEPTH`. `imem_req_addr = pc`.
- Request accepted (`imem_req_valid && imem_req_ready`):
  - `pc <= pc + 4` (wraps 32'hFFFF_FFFC -> 0).
  - `inflight` increments.
  - Address pushed to the address FIFO.
- Response (`imem_resp_valid`):
  - Always: `inflight` decrements and the address FIFO pops.
  - If `drop > 0`: `drop` decrements and the data is discarded.
  - Otherwise: {data, addr} is pushed into the queue.
- Pop: `if_valid && if_ready` removes the head.
- Redirect (`redirect_valid`):
  - `pc <= {redirect_target[31:2], 2'b00}`.
  - Queue is emptied, including any same-cycle push; a same-cycle pop has no effect.
  - `drop <= inflight - (resp consumed this cycle ? 1 : 0)`.
  - No request is issued that cycle.
- Simultaneous accept and response: counters net to zero change.
- Response with `inflight == 0` is a protocol error. Assertion only; behaviour undefined.
- Overflow is impossible: the credit rule guarantees the queue never exceeds DEPTH.

## Timing
- Reset values:
  - Outputs: `imem_req_valid`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus_4`=4.
  - Internal: `pc`=RESET_PC, all counters 0, queue empty.
- First request is presented in the first cycle after `rst` deasserts, with address RESET_PC.
- Queue is registered with no bypass:
  - A response in cycle N gives `if_valid` in N+1 at the earliest.
  - Best-case fetch-to-decode latency is request cycle + memory latency + 1.
- Throughput is 1 instr/cycle when memory latency < DEPTH and decode never stalls.
- Redirect in cycle N:
  - `if_valid`=0 in N+1.
  - Request to the target is presented in N+1 if credit allows.
  - Stale responses are dropped regardless of when they arrive.
- Back-to-back redirects: each overrides the previous; `drop` is recomputed from `inflight` each time.
- `rst` asserted mid-operation clears all state immediately. Responses arriving after reset are protocol errors; the memory must also be reset.
- Outputs to decode hold stable while `if_valid && !if_ready`.

## Test plan
- Reset then 1-cycle memory with `if_ready`=1 -> requests 0x0, 0x4, 0x8... on consecutive cycles; decode sees matching instr/pc one per cycle with `if_pc_plus_4` = pc+4.
- Decode stalled (`if_ready`=0) with DEPTH=2 -> exactly 2 requests issued, queue full, `imem_req_valid`=0; release -> fetching resumes at 0x8.
- 3-cycle memory latency with 2 in flight, redirect to 0x0000_0103 -> next request address 0x0000_0100; the 2 stale responses are discarded; first decoded pc = 0x100.
- Redirect in the same cycle as a response and a decode pop -> `drop` = inflight-1; queue empty next cycle; no stale instruction reaches decode.
- RESET_PC = 32'hFFFF_FFF8, free-running -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; `if_pc_plus_4` for 0xFFFF_FFFC equals 0.
- Assert `rst` while 2 fetches are in flight and the queue is full -> `if_valid` and `imem_req_valid` low immediately; after release, first request is to RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bus bundle (imem request/response, redirect, decode handoff)
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus_4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_target, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus_4,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_target, if_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing in-order word fetches, buffering {instr, pc} for decode,
// with branch redirect that flushes the queue and drops responses still in flight.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic clk,
    input logic rst,
    instruction_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
    logic [PW-1:0] qhead_q, qhead_d, qtail_q, qtail_d, ahead_q, ahead_d, atail_q, atail_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   ipc_q   [DEPTH];
    logic [31:0]   addr_q  [DEPTH];
    logic [CW:0]   used;
    logic          accept, resp, pop, push;

    // Stale fetches still hold an in-flight slot, which keeps the address FIFO at DEPTH entries.
    assign used                = {1'b0, inflight_q} - {1'b0, drop_q} + {1'b0, count_q};
    assign bus.imem_req_valid  = !rst && !bus.redirect_valid && used < LIM && {1'b0, inflight_q} < LIM;
    assign bus.imem_req_addr   = pc_q;
    assign bus.if_valid        = count_q != '0;
    assign bus.if_instr        = instr_q[qhead_q];
    assign bus.if_pc           = ipc_q[qhead_q];
    assign bus.if_pc_plus_4    = ipc_q[qhead_q] + 32'd4;

    assign accept = bus.imem_req_valid && bus.imem_req_ready;
    assign resp   = bus.imem_resp_valid;
    assign pop    = bus.if_valid && bus.if_ready;
    assign push   = resp && drop_q == '0 && !bus.redirect_valid;

    always_comb begin
        pc_d       = bus.redirect_valid ? {bus.redirect_target[31:2], 2'b00} : accept ? pc_q + 32'd4 : pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(resp);
        drop_d     = bus.redirect_valid ? inflight_q - CW'(resp) : drop_q - CW'(resp && drop_q != '0);
        count_d    = bus.redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        qhead_d    = bus.redirect_valid ? qtail_q : qhead_q + PW'(pop);
        qtail_d    = qtail_q + PW'(push);
        ahead_d    = ahead_q + PW'(resp);
        atail_d    = atail_q + PW'(accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            qhead_q    <= '0;
            qtail_q    <= '0;
            ahead_q    <= '0;
            atail_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                ipc_q[i]   <= '0;
                addr_q[i]  <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            qhead_q    <= qhead_d;
            qtail_q    <= qtail_d;
            ahead_q    <= ahead_d;
            atail_q    <= atail_d;
            if (push) begin
                instr_q[qtail_q] <= bus.imem_resp_data;
                ipc_q[qtail_q]   <= addr_q[ahead_q];
            end
            if (accept) addr_q[atail_q] <= pc_q;
        end
    end

    a_resp_has_request: assert property (@(posedge clk) disable iff (rst) bus.imem_resp_valid |-> inflight_q != '0);
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table, randomized queue-model run, reset and PC-wrap sequences.
module tb_instruction_fetch;
    localparam int   DEPTH = 2;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if f1 ();
    instruction_fetch_if f2 ();

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut1 (.clk(clk), .rst(rst), .bus(f1));
    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut2 (.clk(clk), .rst(rst), .bus(f2));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic rdy, rv; logic [31:0] rd; logic ir, redir; logic [31:0] tgt;
        logic ev; logic [31:0] ea; logic eiv; logic [31:0] epc, ei;
    } vec_t;

    typedef struct { logic [31:0] addr; int due; bit stale; } out_t;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mk(input logic rdy, rv, input logic [31:0] rd, input logic ir, redir,
                                input logic [31:0] tgt, input logic ev, input logic [31:0] ea,
                                input logic eiv, input logic [31:0] epc, ei);
        vec_t v;
        v = '{rdy, rv, rd, ir, redir, tgt, ev, ea, eiv, epc, ei};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        f1.imem_req_ready = 0; f1.imem_resp_valid = 0; f1.imem_resp_data = 0;
        f1.redirect_valid = 0; f1.redirect_target = 0; f1.if_ready = 0;
        f2.imem_req_ready = 0; f2.imem_resp_valid = 0; f2.imem_resp_data = 0;
        f2.redirect_valid = 0; f2.redirect_target = 0; f2.if_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(f1.imem_req_valid), 0);
        check("rst_if_valid", 32'(f1.if_valid), 0);
        check("rst_if_instr", f1.if_instr, 0);
        check("rst_if_pc", f1.if_pc, 0);
        check("rst_if_pc_plus_4", f1.if_pc_plus_4, 4);
        check("rst_req_valid2", 32'(f2.imem_req_valid), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t        vt[17];
    out_t        oq[$];
    logic [31:0] qa[$], qi[$];

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mpc;
        logic        rdy, rv, ir, redir, ev, eiv;
        logic [31:0] tgt;
        int          live;
        out_t        h;
        logic        pend;
        logic [31:0] paddr;
        logic [31:0] got[3];
        logic [31:0] exp_a[3];
        int          n;
        bit          seen;

        vt[0]  = mk(H, L, 32'h0,         L, L, 32'h0,   H, 32'h000, L, 32'h000, 32'h0);
        vt[1]  = mk(H, H, mem(32'h0),    L, L, 32'h0,   H, 32'h004, L, 32'h000, 32'h0);
        vt[2]  = mk(H, H, mem(32'h4),    L, L, 32'h0,   L, 32'h000, H, 32'h000, mem(32'h0));
        vt[3]  = mk(H, L, 32'h0,         L, L, 32'h0,   L, 32'h000, H, 32'h000, mem(32'h0));
        vt[4]  = mk(H, L, 32'h0,         H, L, 32'h0,   L, 32'h000, H, 32'h000, mem(32'h0));
        vt[5]  = mk(H, L, 32'h0,         L, L, 32'h0,   H, 32'h008, H, 32'h004, mem(32'h4));
        vt[6]  = mk(L, H, mem(32'h8),    H, L, 32'h0,   L, 32'h000, H, 32'h004, mem(32'h4));
        vt[7]  = mk(L, L, 32'h0,         H, L, 32'h0,   H, 32'h00C, H, 32'h008, mem(32'h8));
        vt[8]  = mk(H, L, 32'h0,         L, H, 32'h103, L, 32'h000, L, 32'h000, 32'h0);
        vt[9]  = mk(H, L, 32'h0,         L, L, 32'h0,   H, 32'h100, L, 32'h000, 32'h0);
        vt[10] = mk(H, L, 32'h0,         L, H, 32'h203, L, 32'h000, L, 32'h000, 32'h0);
        vt[11] = mk(H, L, 32'h0,         L, L, 32'h0,   H, 32'h200, L, 32'h000, 32'h0);
        vt[12] = mk(H, H, 32'hDEAD_BEEF, L, L, 32'h0,   L, 32'h000, L, 32'h000, 32'h0);
        vt[13] = mk(H, H, mem(32'h200),  L, L, 32'h0,   H, 32'h204, L, 32'h000, 32'h0);
        vt[14] = mk(H, H, mem(32'h204),  H, L, 32'h0,   L, 32'h000, H, 32'h200, mem(32'h200));
        vt[15] = mk(H, L, 32'h0,         H, L, 32'h0,   H, 32'h208, H, 32'h204, mem(32'h204));
        vt[16] = mk(L, L, 32'h0,         H, L, 32'h0,   H, 32'h20C, L, 32'h000, 32'h0);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            f1.imem_req_ready = vt[i].rdy; f1.imem_resp_valid = vt[i].rv; f1.imem_resp_data = vt[i].rd;
            f1.if_ready = vt[i].ir; f1.redirect_valid = vt[i].redir; f1.redirect_target = vt[i].tgt;
            #1;
            check($sformatf("vec%0d_req_valid", i), 32'(f1.imem_req_valid), 32'(vt[i].ev));
            if (vt[i].ev) check($sformatf("vec%0d_req_addr", i), f1.imem_req_addr, vt[i].ea);
            check($sformatf("vec%0d_if_valid", i), 32'(f1.if_valid), 32'(vt[i].eiv));
            if (vt[i].eiv) begin
                check($sformatf("vec%0d_if_pc", i), f1.if_pc, vt[i].epc);
                check($sformatf("vec%0d_if_instr", i), f1.if_instr, vt[i].ei);
                check($sformatf("vec%0d_if_pc_plus_4", i), f1.if_pc_plus_4, vt[i].epc + 32'd4);
            end
            @(negedge clk);
        end

        do_reset();
        mpc = 32'h0;
        oq.delete(); qa.delete(); qi.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy   = $urandom_range(0, 3) != 0;
            rv    = oq.size() > 0 && oq[0].due <= cyc && $urandom_range(0, 3) != 0;
            ir    = $urandom_range(0, 3) != 0;
            redir = $urandom_range(0, 15) == 0;
            tgt   = $urandom;
            f1.imem_req_ready = rdy; f1.imem_resp_valid = rv;
            f1.imem_resp_data = rv ? mem(oq[0].addr) : $urandom;
            f1.if_ready = ir; f1.redirect_valid = redir; f1.redirect_target = tgt;
            #1;
            live = 0;
            foreach (oq[k]) if (!oq[k].stale) live++;
            ev  = !redir && (live + qa.size()) < DEPTH && oq.size() < DEPTH;
            eiv = qa.size() > 0;
            check("rand_req_valid", 32'(f1.imem_req_valid), 32'(ev));
            if (ev) check("rand_req_addr", f1.imem_req_addr, mpc);
            check("rand_if_valid", 32'(f1.if_valid), 32'(eiv));
            if (eiv) begin
                check("rand_if_pc", f1.if_pc, qa[0]);
                check("rand_if_instr", f1.if_instr, qi[0]);
                check("rand_if_pc_plus_4", f1.if_pc_plus_4, qa[0] + 32'd4);
            end
            if (eiv && ir) begin
                void'(qa.pop_front());
                void'(qi.pop_front());
            end
            if (rv) begin
                h = oq.pop_front();
                if (!h.stale) begin
                    qa.push_back(h.addr);
                    qi.push_back(mem(h.addr));
                end
            end
            if (ev && rdy) begin
                oq.push_back('{mpc, cyc + 1 + int'($urandom_range(0, 3)), 1'b0});
                mpc = mpc + 32'd4;
            end
            if (redir) begin
                qa.delete(); qi.delete();
                foreach (oq[k]) oq[k].stale = 1'b1;
                mpc = {tgt[31:2], 2'b00};
            end
            @(negedge clk);
        end

        do_reset();
        f1.imem_req_ready = 1'b1; f1.if_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            f1.imem_resp_valid = c == 1 || c == 2;
            f1.imem_resp_data  = mem(32'(c - 1) << 2);
            #1;
            @(negedge clk);
        end
        f1.imem_resp_valid = 1'b0;
        #1;
        check("full_if_valid", 32'(f1.if_valid), 1);
        check("full_req_valid", 32'(f1.imem_req_valid), 0);
        #1 rst = 1'b1;
        #1;
        check("midrst_if_valid", 32'(f1.if_valid), 0);
        check("midrst_req_valid", 32'(f1.imem_req_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_req_valid", 32'(f1.imem_req_valid), 1);
        check("postrst_req_addr", f1.imem_req_addr, 32'h0);
        @(negedge clk);

        do_reset();
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        got   = '{32'h1, 32'h1, 32'h1};
        pend = 1'b0; paddr = 32'h0; n = 0; seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            f2.imem_req_ready = 1'b1; f2.if_ready = 1'b1;
            f2.imem_resp_valid = pend; f2.imem_resp_data = mem(paddr);
            #1;
            if (f2.if_valid && f2.if_pc == 32'hFFFF_FFFC) begin
                seen = 1'b1;
                check("wrap_pc_plus_4", f2.if_pc_plus_4, 32'h0);
            end
            pend = f2.imem_req_valid;
            if (pend) begin
                paddr = f2.imem_req_addr;
                if (n < 3) got[n] = paddr;
                n++;
            end
            @(negedge clk);
        end
        check("wrap_req_count_ge3", 32'(n >= 3), 1);
        for (int i = 0; i < 3; i++) check($sformatf("wrap_addr%0d", i), got[i], exp_a[i]);
        check("wrap_pc4_seen", 32'(seen), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
